// File: rtl/biquad8_loader_pkg.sv
// Shared types and register map for the biquad8 coefficient loader.
// Optional commit write is enabled by defining BIQUAD8_LOADER_UPDATE_EN.
package biquad8_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WRITE,
    S_GAP,
    S_FINISH
`ifdef BIQUAD8_LOADER_UPDATE_EN
    , S_UPDATE
`endif
  } state_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_BUS_ERR = 2'd1,
    STAT_TIMEOUT = 2'd2
  } status_e;

  localparam logic [6:0] ADR_UPDATE    = 7'h00;
  localparam logic [6:0] ADR_ZERO_FIR  = 7'h04;
  localparam logic [6:0] ADR_POLE_IIR  = 7'h08;
  localparam logic [6:0] ADR_POLE_FIR0 = 7'h10;
  localparam logic [6:0] ADR_POLE_FIR1 = 7'h14;
  localparam logic [6:0] ADR_POLE_FIR2 = 7'h18;
  localparam logic [6:0] ADR_POLE_FIR3 = 7'h1C;

  // Pole-FIR bank j (0..3) to its register address.
  function automatic logic [6:0] pole_fir_adr(input int unsigned j);
    case (j)
      0:       return ADR_POLE_FIR0;
      1:       return ADR_POLE_FIR1;
      2:       return ADR_POLE_FIR2;
      default: return ADR_POLE_FIR3;
    endcase
  endfunction

endpackage

// File: rtl/biquad8_coeff_loader.sv
// Walks the coefficient table and writes each entry to the biquad over a
// Wishbone initiator. Define BIQUAD8_LOADER_UPDATE_EN to append the commit
// write (adr 0x00, data 1) after the last coefficient.
module biquad8_coeff_loader
  import biquad8_loader_pkg::*;
#(
  parameter int unsigned NFIR     = 8,
  parameter int unsigned NPOLE    = 2,
  parameter int unsigned NIIR     = 4,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TABLE_AW = 6
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          status_o,
  output logic                coeff_rd_o,
  output logic [TABLE_AW-1:0] coeff_adr_o,
  input  logic [17:0]         coeff_dat_i,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [6:0]          wb_adr_o,
  output logic [31:0]         wb_dat_o,
  output logic [3:0]          wb_sel_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic                wb_rty_i,
  input  logic [31:0]         wb_dat_i
);

  localparam int unsigned TOTAL = NFIR + 4 * NPOLE + NIIR;
  localparam int unsigned IDXW  = (TOTAL < 2) ? 1 : $clog2(TOTAL + 1);
  localparam int unsigned TMOW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TOTAL - 1);

  if (TOTAL > (1 << TABLE_AW)) begin : g_table_too_small
    $error("biquad8_coeff_loader: NFIR+4*NPOLE+NIIR exceeds 2**TABLE_AW");
  end

  state_e            state_q, state_d;
  status_e           status_q, status_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [TMOW-1:0]   tmo_q, tmo_d;
  logic              rgap_q, rgap_d;
  logic [6:0]        adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [3:0]        sel_q, sel_d;

  logic              in_bus;
  state_e            ack_next;

  logic              unused_dat;
  assign unused_dat = ^wb_dat_i;

  // Table index to destination register.
  function automatic logic [6:0] target_adr(input logic [IDXW-1:0] idx);
    int unsigned i;
    i = 32'(idx);
    if (i < NFIR) return ADR_ZERO_FIR;
    if (i < NFIR + 4 * NPOLE) return pole_fir_adr((i - NFIR) / NPOLE);
    return ADR_POLE_IIR;
  endfunction

  // Next-state, handshake and timeout decisions.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    idx_d    = idx_q;
    tmo_d    = '0;
    rgap_d   = 1'b0;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;

`ifdef BIQUAD8_LOADER_UPDATE_EN
    in_bus   = (state_q == S_WRITE) || (state_q == S_UPDATE);
    ack_next = (state_q == S_UPDATE) ? S_FINISH : S_GAP;
`else
    in_bus   = (state_q == S_WRITE);
    ack_next = S_GAP;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_FETCH;
          status_d = STAT_OK;
          idx_d    = '0;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        dat_d   = 32'(coeff_dat_i);
        adr_d   = target_adr(idx_q);
        sel_d   = 4'hF;
        state_d = S_WRITE;
      end
      S_GAP: begin
        if (idx_q == LAST_IDX) begin
`ifdef BIQUAD8_LOADER_UPDATE_EN
          state_d = S_UPDATE;
          adr_d   = ADR_UPDATE;
          dat_d   = 32'h1;
          sel_d   = 4'h1;
`else
          state_d = S_FINISH;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default: ;
    endcase

    // Shared by coefficient and commit writes; a retry holds stb low for the
    // rgap cycle with the timeout counter parked at zero.
    if (in_bus && !rgap_q) begin
      if (wb_err_i) begin
        state_d  = S_FINISH;
        status_d = STAT_BUS_ERR;
      end else if (wb_ack_i) begin
        state_d = ack_next;
      end else if (wb_rty_i) begin
        rgap_d = 1'b1;
      end else if (tmo_q == TMOW'(TIMEOUT - 1)) begin
        state_d  = S_FINISH;
        status_d = STAT_TIMEOUT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= S_IDLE;
      status_q <= STAT_OK;
      idx_q    <= '0;
      tmo_q    <= '0;
      rgap_q   <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      rgap_q   <= rgap_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_FINISH);
  assign status_o    = status_q;
  assign coeff_rd_o  = (state_q == S_FETCH);
  assign coeff_adr_o = TABLE_AW'(idx_q);
  assign wb_cyc_o    = in_bus;
  assign wb_stb_o    = in_bus && !rgap_q;
  assign wb_we_o     = in_bus;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;

endmodule
